// File: rtl/mux_nway_scan.sv
// N-way registered channel mux with direct select and timed scan rotation.
// Feeds display/debug channel rotation in the CPU and test-harness layer.
module mux_nway_scan #(
  parameter int N     = 8,
  parameter int WIDTH = 16,
  parameter int SW    = (N > 2) ? $clog2(N) : 1,
  parameter int DW    = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SW-1:0]      sel_in,
  input  logic [DW-1:0]      dwell,
  input  logic [N*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]   out,
  output logic [SW-1:0]      cur_sel,
  output logic               out_valid,
  output logic               wrap,
  output logic               sel_err
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);
  localparam logic [SW:0]   NV   = (SW + 1)'(N);

  logic [DW-1:0]    cnt;
  logic [DW-1:0]    cnt_eff;
  logic [DW-1:0]    cnt_nxt;
  logic             mode_q;
  logic [SW-1:0]    sel_nxt;
  logic             wrap_nxt;
  logic             err_nxt;
  logic [WIDTH-1:0] ch_out;

  // count only carries over between consecutive enabled scan edges
  always_comb begin
    cnt_eff  = mode_q ? cnt : '0;
    sel_nxt  = cur_sel;
    cnt_nxt  = '0;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (mode) begin
      if (cnt_eff >= dwell) begin
        wrap_nxt = (cur_sel == LAST);
        sel_nxt  = wrap_nxt ? '0 : cur_sel + 1'b1;
      end else begin
        cnt_nxt = cnt_eff + 1'b1;
      end
    end else if ({1'b0, sel_in} < NV) begin
      sel_nxt = sel_in;
    end else begin
      err_nxt = 1'b1;
    end
  end

  always_comb begin
    ch_out = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_nxt == SW'(k)) begin
        ch_out = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out       <= '0;
      cur_sel   <= '0;
      cnt       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
    end else if (en) begin
      out       <= ch_out;
      cur_sel   <= sel_nxt;
      cnt       <= cnt_nxt;
      mode_q    <= mode;
      out_valid <= 1'b1;
      wrap      <= wrap_nxt;
      sel_err   <= err_nxt;
    end else begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nway_scan.sv
// Scoreboard bench for mux_nway_scan: an 8-way and a 5-way instance
// share control inputs and are checked against a reference model.
module tb_mux_nway_scan;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset_n;
  logic         en;
  logic         mode;
  logic [2:0]   sel_in;
  logic [7:0]   dwell;
  logic [15:0]  ch [8];
  logic [127:0] bus8;
  logic [79:0]  bus5;

  for (genvar k = 0; k < 8; k++) begin : g_b8
    assign bus8[k*16 +: 16] = ch[k];
  end
  for (genvar k = 0; k < 5; k++) begin : g_b5
    assign bus5[k*16 +: 16] = ch[k];
  end

  logic [15:0] o8, o5;
  logic [2:0]  c8, c5;
  logic        v8, v5, w8, w5, e8, e5;

  mux_nway_scan #(.N(8), .WIDTH(16), .SW(3), .DW(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .en(en), .mode(mode),
    .sel_in(sel_in), .dwell(dwell), .in_bus(bus8),
    .out(o8), .cur_sel(c8), .out_valid(v8), .wrap(w8), .sel_err(e8)
  );

  mux_nway_scan #(.N(5), .WIDTH(16), .SW(3), .DW(8)) dut5 (
    .clock(clock), .reset_n(reset_n), .en(en), .mode(mode),
    .sel_in(sel_in), .dwell(dwell), .in_bus(bus5),
    .out(o5), .cur_sel(c5), .out_valid(v5), .wrap(w5), .sel_err(e5)
  );

  typedef struct {
    int          cnt;
    int          cur;
    bit          mq;
    logic [15:0] out;
    bit          val;
    bit          wrp;
    bit          err;
  } st_t;

  st_t m8, m5;
  st_t q [$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic st_t step(input st_t s, input int n);
    st_t r = s;
    int  c;
    if (!reset_n) begin
      r = '{0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
    end else if (!en) begin
      r.val = 0;
      r.wrp = 0;
      r.err = 0;
    end else begin
      r.val = 1;
      r.wrp = 0;
      r.err = 0;
      if (!mode) begin
        if (int'(sel_in) < n) r.cur = int'(sel_in);
        else r.err = 1;
        r.cnt = 0;
      end else begin
        c = s.mq ? s.cnt : 0;
        if (c >= int'(dwell)) begin
          r.cnt = 0;
          r.wrp = (s.cur == n - 1);
          r.cur = r.wrp ? 0 : s.cur + 1;
        end else begin
          r.cnt = c + 1;
        end
      end
      r.mq  = mode;
      r.out = ch[r.cur];
    end
    return r;
  endfunction

  task automatic cyc();
    st_t e;
    m8 = step(m8, 8);
    m5 = step(m5, 5);
    q.push_back(m8);
    q.push_back(m5);
    @(posedge clock);
    #1;
    e = q.pop_front();
    chk("out8", 32'(o8), 32'(e.out));
    chk("sel8", 32'(c8), 32'(e.cur));
    chk("vld8", 32'(v8), 32'(e.val));
    chk("wrp8", 32'(w8), 32'(e.wrp));
    chk("err8", 32'(e8), 32'(e.err));
    e = q.pop_front();
    chk("out5", 32'(o5), 32'(e.out));
    chk("sel5", 32'(c5), 32'(e.cur));
    chk("vld5", 32'(v5), 32'(e.val));
    chk("wrp5", 32'(w5), 32'(e.wrp));
    chk("err5", 32'(e5), 32'(e.err));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  initial begin
    m8 = '{0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
    m5 = m8;
    for (int k = 0; k < 8; k++) ch[k] = 16'(k);
    reset_n = 0; en = 1; mode = 0; sel_in = 0; dwell = 0;
    #1;
    run(2);
    chk("rst_out8", 32'(o8), 32'h0);
    chk("rst_sel8", 32'(c8), 32'h0);

    // direct sweep
    reset_n = 1;
    for (int s = 0; s < 8; s++) begin
      sel_in = 3'(s);
      cyc();
      chk("dir_out8", 32'(o8), 32'(s));
    end

    // scan dwell=4 from reset
    reset_n = 0; cyc(); reset_n = 1;
    mode = 1; dwell = 4;
    run(45);

    // out-of-range select on the 5-way instance, then fast scan
    mode = 0; sel_in = 3; cyc();
    sel_in = 6; cyc();
    chk("err5_pulse", 32'(e5), 32'h1);
    chk("sel5_hold", 32'(c5), 32'h3);
    sel_in = 3; cyc();
    mode = 1; dwell = 0; run(12);

    // freeze mid-dwell
    dwell = 3; run(2);
    en = 0; run(7);
    en = 1; run(10);

    // reset mid-scan at channel 5
    for (int i = 0; i < 40 && m8.cur != 5; i++) cyc();
    chk("at5", 32'(c8), 32'h5);
    reset_n = 0; cyc();
    reset_n = 1; run(10);

    // direct -> scan -> direct
    mode = 0; sel_in = 2; cyc();
    mode = 1; dwell = 2; run(7);
    mode = 0; sel_in = 6; cyc();
    chk("back_dir8", 32'(c8), 32'h6);

    // live dwell compare
    mode = 1; dwell = 10; run(3);
    dwell = 1; run(4);

    // mode flips while disabled
    run(1); en = 0; mode = 0; run(1); mode = 1; run(1); en = 1; run(4);

    // maximum dwell
    dwell = 8'hff; run(520);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 40) != 0);
      en      = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel_in  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) dwell = 8'($urandom_range(0, 3));
      ch[$urandom_range(0, 7)] = 16'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
